// File: rtl/pi_share_scheduler.sv
// Shares one fixed-latency error/PI datapath among N_REQ loops: capture, arbitrate, issue, route results back.
// Define RR_ARBITER_EN for round-robin arbitration; the default build uses fixed priority (lowest index wins).

module pi_share_slot (
  input  logic        clk,
  input  logic        rst,
  input  logic        rst_user,
  input  logic        req,
  input  logic        gnt,
  input  logic [63:0] opa,
  input  logic [63:0] opb,
  output logic        pending,
  output logic        err,
  output logic [63:0] cap_a,
  output logic [63:0] cap_b
);
  logic take;
  assign take = req && (!pending || gnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
      err     <= 1'b0;
      cap_a   <= '0;
      cap_b   <= '0;
    end else if (rst_user) begin
      pending <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (take) begin
        cap_a <= opa;
        cap_b <= opb;
      end
      // the grant consumes the old pair before a same-cycle request re-arms the slot
      pending <= take || (pending && !gnt);
      if (req && pending && !gnt) err <= 1'b1;
    end
  end
endmodule

module pi_share_scheduler #(
  parameter int N_REQ = 4,
  parameter int TAG_W = 2,
  parameter int LAT   = 26
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rst_user,
  input  logic [N_REQ-1:0]      req,
  input  logic [64*N_REQ-1:0]   opa_i,
  input  logic [64*N_REQ-1:0]   opb_i,
  output logic                  issue_valid,
  output logic [63:0]           issue_a,
  output logic [63:0]           issue_b,
  output logic [TAG_W-1:0]      issue_tag,
  input  logic [63:0]           res_i,
  output logic [63:0]           result_o,
  output logic [TAG_W-1:0]      result_tag,
  output logic [N_REQ-1:0]      done,
  output logic [N_REQ-1:0]      err,
  output logic                  busy
);
  logic [N_REQ-1:0]            pending, gnt;
  logic [N_REQ-1:0][63:0]      cap_a, cap_b;
  logic                        gnt_any;
  logic [TAG_W-1:0]            gnt_idx;
  logic [63:0]                 sel_a, sel_b;
  logic [LAT-1:0]              vld_pipe;
  logic [LAT-1:0][TAG_W-1:0]   tag_pipe;

  for (genvar i = 0; i < N_REQ; i++) begin : g_slot
    pi_share_slot u_slot (
      .clk      (clk),
      .rst      (rst),
      .rst_user (rst_user),
      .req      (req[i]),
      .gnt      (gnt[i]),
      .opa      (opa_i[64*i +: 64]),
      .opb      (opb_i[64*i +: 64]),
      .pending  (pending[i]),
      .err      (err[i]),
      .cap_a    (cap_a[i]),
      .cap_b    (cap_b[i])
    );
  end

`ifdef RR_ARBITER_EN
  logic [TAG_W-1:0] ptr;

  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!gnt_any && pending[idx]) begin
        gnt_any  = 1'b1;
        gnt_idx  = TAG_W'(idx);
        gnt[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ptr <= '0;
    else if (gnt_any) ptr <= (int'(gnt_idx) == N_REQ-1) ? '0 : gnt_idx + 1'b1;
  end
`else
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!gnt_any && pending[i]) begin
        gnt_any = 1'b1;
        gnt_idx = TAG_W'(i);
        gnt[i]  = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_a |= cap_a[i];
        sel_b |= cap_b[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_valid <= 1'b0;
      issue_a     <= '0;
      issue_b     <= '0;
      issue_tag   <= '0;
    end else if (rst_user) begin
      issue_valid <= 1'b0;
    end else begin
      issue_valid <= gnt_any;
      if (gnt_any) begin
        issue_a   <= sel_a;
        issue_b   <= sel_b;
        issue_tag <= gnt_idx;
      end
    end
  end

  // tag valids shadow the datapath so each result finds its owner LAT cycles later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      for (int i = LAT-1; i > 0; i--) begin
        vld_pipe[i] <= vld_pipe[i-1] && !rst_user;
        tag_pipe[i] <= tag_pipe[i-1];
      end
      vld_pipe[0] <= issue_valid && !rst_user;
      tag_pipe[0] <= issue_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_o   <= '0;
      result_tag <= '0;
      done       <= '0;
    end else if (rst_user) begin
      done <= '0;
    end else begin
      if (vld_pipe[LAT-1]) begin
        result_o   <= res_i;
        result_tag <= tag_pipe[LAT-1];
      end
      for (int i = 0; i < N_REQ; i++)
        done[i] <= vld_pipe[LAT-1] && (tag_pipe[LAT-1] == TAG_W'(i));
    end
  end

  assign busy = (|pending) | issue_valid | (|vld_pipe) | (|done);
endmodule
